// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// enforces a bounded memory wait, raises a sticky trap and counts retired instructions.
module mc_ctrl_fsm #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4,
    parameter int EN_RV32M = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic [3:0]       st,
    output logic             pc_we,
    output logic             ir_we,
    output logic             ab_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             alu_src_imm,
    output logic             mem_req,
    output logic             mem_we,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB       = 4'd4,
        S_EXEC_I   = 4'd5,
        S_LUI      = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_LD_WB    = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STOR = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    state_t            state;
    state_t            nxt;
    logic [1:0]        nxt_cause;
    logic [WAIT_W-1:0] wcnt;
    logic              in_wait;
    logic              timeout;
    logic              retire;
    logic              r_legal;

    assign st      = state;
    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    // Ready on the limit cycle takes priority over the timeout.
    assign timeout = (MAX_WAIT > 0) && in_wait && !mem_ready && (wcnt == WAIT_LAST);

    always_comb begin
        r_legal = 1'b0;
        case (func7)
            7'h00:   r_legal = 1'b1;
            7'h20:   r_legal = (func3 == 3'b000) || (func3 == 3'b101);
            7'h01:   r_legal = (EN_RV32M != 0);
            default: r_legal = 1'b0;
        endcase
    end

    always_comb begin
        nxt       = state;
        nxt_cause = CAUSE_NONE;
        retire    = 1'b0;
        case (state)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    nxt = S_DECODE;
                end else if (timeout) begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R: begin
                        if (r_legal) begin
                            nxt = S_EXEC_R;
                        end else begin
                            nxt       = S_TRAP;
                            nxt_cause = CAUSE_ILLEGAL;
                        end
                    end
                    OP_IMM:           nxt = S_EXEC_I;
                    OP_LUI:           nxt = S_LUI;
                    OP_LOAD, OP_STOR: nxt = S_MEM_ADDR;
                    OP_BR:            nxt = S_BRANCH;
                    OP_JAL:           nxt = S_JAL;
                    default: begin
                        nxt       = S_TRAP;
                        nxt_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_WB;
            S_WB, S_LUI, S_LD_WB, S_BRANCH, S_JAL: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LOAD) begin
                    nxt = S_MEM_RD;
                end else if (opcode == OP_STOR) begin
                    nxt = S_MEM_WR;
                end else begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_ILLEGAL;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) begin
                    nxt = S_LD_WB;
                end else if (timeout) begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    nxt    = S_FETCH;
                    retire = 1'b1;
                end else if (timeout) begin
                    nxt       = S_TRAP;
                    nxt_cause = CAUSE_TIMEOUT;
                end
            end
            S_TRAP: nxt = S_TRAP;
            default: begin
                nxt       = S_TRAP;
                nxt_cause = CAUSE_ILLEGAL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            instret    <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                wcnt <= '0;
            end else if (in_wait && !mem_ready) begin
                wcnt <= wcnt + 1'b1;
            end
            if ((nxt == S_TRAP) && (state != S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= nxt_cause;
            end
            if (retire) begin
                instret <= instret + 1'b1;
            end
        end
    end

    always_comb begin
        pc_we       = ((state == S_FETCH) && mem_ready) || ((state == S_BRANCH) && br_taken)
                      || (state == S_JAL);
        ir_we       = (state == S_FETCH) && mem_ready;
        ab_we       = (state == S_DECODE);
        rf_we       = (state == S_WB) || (state == S_LUI) || (state == S_LD_WB) || (state == S_JAL);
        alu_src_imm = (state == S_EXEC_I) || (state == S_MEM_ADDR);
        mem_req     = in_wait;
        mem_we      = (state == S_MEM_WR);
        case (state)
            S_LUI:   wb_sel = 2'd1;
            S_LD_WB: wb_sel = 2'd2;
            S_JAL:   wb_sel = 2'd3;
            default: wb_sel = 2'd0;
        endcase
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multi-cycle RV32I control FSM: the next-generation control unit for the multi-cycle CPU datapath.
- Covers R-type, OP-IMM, LUI, LOAD, STORE, BRANCH and JAL, with optional RV32M acceptance.
- Memory accesses use a ready handshake with a bounded wait timeout, and the block keeps a retired-instruction counter.
- Sits between the instruction register decode fields and the datapath enables, muxes and memory port.

Parameters:
MAX_WAIT, 8, memory wait limit in cycles per access; 0 disables the timeout.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.
EN_RV32M, 0, 1 accepts func7=7'b0000001 R-type (MUL/DIV) as legal.
CNT_W, 32, width of instret.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
opcode  in  7  instruction opcode, taken from the IR.
func3  in  3  instruction func3.
func7  in  7  instruction func7.
br_taken  in  1  branch-compare result from the ALU.
mem_ready  in  1  memory completes the current request this cycle.
st  out  4  current state code.
pc_we  out  1  PC write enable.
ir_we  out  1  IR write enable.
ab_we  out  1  latch register-file operands A/B.
rf_we  out  1  register-file write enable.
wb_sel  out  2  writeback source: 0=ALU, 1=imm, 2=mem, 3=PC+4.
alu_src_imm  out  1  ALU operand B = immediate.
mem_req  out  1  memory request.
mem_we  out  1  memory write; valid only when mem_req=1.
trap  out  1  sticky trap flag.
trap_cause  out  2  0=none, 1=illegal instruction, 2=memory timeout.
instret  out  CNT_W  count of retired instructions.

Behaviour:
- Reset: on any posedge clk with rst=1, st<=0, wait counter<=0, trap<=0, trap_cause<=0, instret<=0. Reset applies in every state, including mid memory wait.
- In st=0 every strobe is 0 and wb_sel=0. Outputs are decoded from st (Moore), except the ready- and branch-qualified strobes noted below.
- State transitions:
  - 0 IDLE -> 1.
  - 1 FETCH: mem_req=1, mem_we=0. On mem_ready=1: ir_we=1, pc_we=1 (PC+4), next state 2. Otherwise stay in 1.
  - 2 DECODE: ab_we=1, then dispatch on opcode:
    - 0110011 -> 3, if func7 is legal; otherwise -> 15.
    - 0010011 -> 5.
    - 0110111 -> 6.
    - 0000011 or 0100011 -> 7.
    - 1100011 -> 10.
    - 1101111 -> 11.
    - any other opcode -> 15, cause=1.
  - R-type func7 legality:
    - 7'h00 is legal with any func3.
    - 7'h20 is legal only with func3 000 or 101.
    - 7'h01 is legal only when EN_RV32M=1.
    - Anything else is illegal (cause=1).
  - 3 EXEC_R: alu_src_imm=0 -> 4.
  - 5 EXEC_I: alu_src_imm=1 -> 4.
  - 4 WB: rf_we=1, wb_sel=0 -> 1.
  - 6 LUI: rf_we=1, wb_sel=1 -> 1.
  - 7 MEM_ADDR: alu_src_imm=1. Next state 8 if opcode=LOAD, 9 if STORE.
  - 8 MEM_RD: mem_req=1, mem_we=0. On mem_ready=1 -> 12.
  - 12 LD_WB: rf_we=1, wb_sel=2 -> 1.
  - 9 MEM_WR: mem_req=1, mem_we=1. On mem_ready=1 -> 1.
  - 10 BRANCH: pc_we=br_taken -> 1.
  - 11 JAL: rf_we=1, wb_sel=3, pc_we=1 -> 1.
  - 15 TRAP: all strobes 0, trap=1, trap_cause held. Stays in 15 until rst.
  - Unused codes (13, 14) -> 15 with cause=1.
- Wait counter (states 1, 8, 9):
  - Cleared on entry to the state.
  - Increments each cycle mem_ready=0.
  - If MAX_WAIT>0 and the counter equals MAX_WAIT-1 with mem_ready=0: next state 15, cause=2.
  - Trap entry is at most MAX_WAIT cycles after entering the wait state.
  - mem_ready=1 on the limit cycle completes normally; ready wins.
  - mem_ready=1 on the entry cycle gives a single-cycle access.
- instret:
  - Increments by 1 on the cycle the FSM leaves 4, 6, 9, 10, 11 or 12 toward 1.
  - Wraps modulo 2^CNT_W.
  - Never increments on a trap or an aborted instruction.
- trap_cause is written once, on entry to 15, and holds until reset.

Test Plan:
- ADD (opcode 0110011, func7 00), mem_ready=1 throughout -> st sequence 0,1,2,3,4,1; rf_we=1 only in st=4; instret=1 after 5 cycles.
- LW, mem_ready low 2 cycles in both FETCH and MEM_RD -> st 1,1,1,2,7,8,8,8,12,1; wb_sel=2 with rf_we=1 in st=12; instret=1.
- MAX_WAIT=8, mem_ready held 0 in FETCH -> 8 cycles in st=1, then st=15, trap=1, trap_cause=2; instret unchanged. Repeat with ready asserted on the 8th cycle -> st=2, no trap.
- opcode 7'h7F -> DECODE then st=15, cause=1. SUB with func3 001 (func7 20) -> trap, cause=1.
- func7=01 R-type: EN_RV32M=0 -> trap, cause=1; EN_RV32M=1 -> st 3,4, instret increments.
- BEQ with br_taken=0 then 1 -> pc_we in st=10 is 0 then 1; instret increments each time.
- rst=1 asserted while in st=8 waiting -> next cycle st=0, all strobes 0, instret=0, trap=0.
